// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR sequencer: one shared unsigned 8x8 multiplier walks
// the taps serially, accumulating into a wrapping ACC_W-bit sum.
module fir_mac_sched #(
  parameter int TAPS  = 4,
  parameter int ACC_W = 18,
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coef_we,
  input  logic [TW-1:0]    coef_addr,
  input  logic [7:0]       coef_data,
  output logic             coef_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t           state_q;
  logic [7:0]       x_q    [TAPS];
  logic [7:0]       coef_q [TAPS];
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [TW-1:0]    tap_q;
  logic [ACC_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             coef_err_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             addr_ok_s;

  assign addr_ok_s = (int'(coef_addr) < TAPS);

  always_comb begin
    acc_d = acc_q + {{(ACC_W-16){1'b0}}, mul_p};
  end

  // Multiplier operands stay at zero outside MAC to keep the shared unit quiet.
  assign mul_a     = (state_q == MAC) ? x_q[tap_q]    : 8'd0;
  assign mul_b     = (state_q == MAC) ? coef_q[tap_q] : 8'd0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign coef_err  = coef_err_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= 8'd0;
        coef_q[k] <= 8'd0;
      end
    end else begin
      coef_err_q <= 1'b0;
      // Writes land only while idle; a write alongside a handshake feeds the next MAC.
      if (coef_we && addr_ok_s) begin
        if (state_q == IDLE) begin
          coef_q[coef_addr] <= coef_data;
        end else begin
          coef_err_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              x_q[k] <= x_q[k-1];
            end
            acc_q      <= '0;
            tap_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + 1'b1;
          if (tap_q == TW'(TAPS - 1)) begin
            out_data_q  <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed plus randomized bench for fir_mac_sched; the multiplier is modelled
// here and expected outputs come from a sample-history FIR sum.
module tb_fir_mac_sched;
  localparam int TAPS  = 4;
  localparam int ACC_W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [7:0]        coef_data;
  logic              coef_err;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_p;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  int                n_pass = 0;
  int                n_fail = 0;
  int                n_total = 0;
  int                hist[$];
  int                cs[TAPS];

  fir_mac_sched #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    longint s = 0;
    for (int k = 0; k < hist.size() && k < TAPS; k++) s += longint'(cs[k]) * longint'(hist[k]);
    return int'(s % (64'd1 << ACC_W));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < TAPS; k++) cs[k] = 0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
    cs[a] = int'(d);
    chk("idle_write_no_err", 32'(coef_err), 32'd0);
  endtask

  // One sample through the block: optional same-cycle coef write, optional
  // write during MAC, `hold` cycles of output backpressure, optional held in_valid.
  task automatic send(input logic [7:0] d, input bit wr, input logic [1:0] wa,
                      input logic [7:0] wd, input bit bwr, input int hold, input bit keep);
    int y;
    int guard = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    if (wr) begin coef_we = 1'b1; coef_addr = wa; coef_data = wd; cs[wa] = int'(wd); end
    tick();
    coef_we = 1'b0;
    if (!keep) in_valid = 1'b0;
    hist.push_front(int'(d));
    if (hist.size() > TAPS) void'(hist.pop_back());
    y = model_y();
    out_ready = (hold == 0);
    chk("mul_a_tap0", 32'(mul_a), 32'(d));
    chk("mul_b_tap0", 32'(mul_b), 32'(cs[0]));
    for (int i = 1; i < TAPS; i++) begin
      if (bwr && i == 1) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'hAA;
        tick();
        coef_we = 1'b0;
        chk("busy_write_err", 32'(coef_err), 32'd1);
      end else begin
        tick();
        if (bwr && i == 2) chk("busy_err_one_cycle", 32'(coef_err), 32'd0);
      end
    end
    chk("mac_no_valid", 32'(out_valid), 32'd0);
    chk("mac_busy", 32'(busy), 32'd1);
    tick();
    chk("valid_at_latency", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(y));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(y));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("accept_valid_drop", 32'(out_valid), 32'd0);
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    chk("idle_mul_a", 32'(mul_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1; coef_we = 1'b0; coef_addr = 2'd0; coef_data = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_coef_err", 32'(coef_err), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);

    // Impulse response with coefficients 1..4.
    for (int k = 0; k < TAPS; k++) write_coef(2'(k), 8'(k + 1));
    send(8'd1, 1'b0, 2'd0, 8'd0, 1'b0, 0, 1'b0);
    chk("impulse_0", 32'(out_data), 32'd1);
    for (int k = 1; k < TAPS; k++) begin
      send(8'd0, 1'b0, 2'd0, 8'd0, 1'b0, 0, 1'b0);
      chk("impulse_k", 32'(out_data), 32'(k + 1));
    end

    // Write while busy is dropped; the response still uses coef[0]=1.
    send(8'd1, 1'b0, 2'd0, 8'd0, 1'b1, 0, 1'b0);
    chk("busy_write_dropped", 32'(out_data), 32'd1);

    // Backpressure for 5 cycles.
    send(8'd0, 1'b0, 2'd0, 8'd0, 1'b0, 5, 1'b0);
    chk("backpressure_data", 32'(out_data), 32'd2);

    // Full-scale sum, no wrap.
    for (int k = 0; k < TAPS; k++) write_coef(2'(k), 8'd255);
    for (int k = 0; k < TAPS; k++) send(8'd255, 1'b0, 2'd0, 8'd0, 1'b0, 0, 1'b0);
    chk("max_sum", 32'(out_data), 32'h3F804);

    // Reset in the middle of MAC discards the result.
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < TAPS + 2; i++) begin
      tick();
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    send(8'd77, 1'b0, 2'd0, 8'd0, 1'b0, 0, 1'b0);
    chk("post_rst_zero", 32'(out_data), 32'd0);
    send(8'd5, 1'b1, 2'd0, 8'd1, 1'b0, 0, 1'b0);
    chk("same_cycle_write", 32'(out_data), 32'd5);

    // Streaming with in_valid held high.
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int k = 0; k < TAPS; k++) write_coef(2'(k), 8'd1);
    for (int s = 1; s <= 5; s++) send(8'(10 * s), 1'b0, 2'd0, 8'd0, 1'b0, 0, s < 5);
    chk("stream_last", 32'(out_data), 32'd140);

    // Randomized traffic with coefficient updates and backpressure.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) write_coef(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
